seg_text_scroller: RTL
======================

Name: seg_text_scroller

Overview:
Producer side of the 4-digit display interface. It accepts a message of 5-bit character codes over a valid/ready write port and stores it in a small buffer. It then scrolls the message right-to-left across the 4-digit window and drives the packed 20-bit seg_data word consumed by the multiplexed 7-segment display controller.

Parameters:
DEPTH, 16, message buffer capacity in characters (2..31)
SCROLL_DIV, 25000000, clk cycles per scroll step (>=2)
BLANK_CODE, 5'h1F, character code used for blank padding positions

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
char_in  input  5  character code to append to message
char_valid  input  1  char_in valid; write occurs when char_valid && char_ready
char_ready  output  1  buffer accepts a character this cycle
msg_commit  input  1  single-cycle pulse: end loading, start scrolling
msg_clear  input  1  single-cycle pulse: discard message, return to IDLE
scroll_en  input  1  1 = scroll advances; 0 = freeze current window
seg_data  output  20  {digit3(leftmost)[19:15], digit2, digit1, digit0(rightmost)[4:0]}
msg_len  output  5  number of stored characters
scrolling  output  1  high while in SCROLL state
wrap_pulse  output  1  one-cycle pulse when window returns to position 0

Behaviour:
- One clock, synchronous active-high reset. Reset values: state=IDLE, msg_len=0, pos=0, tick=0, seg_data={4{BLANK_CODE}}, char_ready=1, scrolling=0, wrap_pulse=0.
- States:
  - IDLE: buffer empty, char_ready=1. An accepted char is written to buf[0], msg_len=1, next state LOAD. msg_commit is ignored.
  - LOAD: char_ready = (msg_len < DEPTH). An accepted char is written to buf[msg_len] and msg_len increments. On msg_commit, next state is SCROLL with pos=0 and tick=0. If a char is accepted in the same cycle as msg_commit, the char is stored and included in the message.
  - SCROLL: char_ready=0, scrolling=1. Buffer contents and msg_len are frozen.
- msg_clear in any state: next state IDLE, msg_len=0, pos=0, tick=0. It has priority over msg_commit and over a simultaneous char write; that char is dropped.
- Virtual stream: length L = msg_len + 4. stream[i] = BLANK_CODE for i<4, and buf[i-4] for 4<=i<L.
- Window at position pos: digit3=stream[pos], digit2=stream[(pos+1) mod L], digit1=stream[(pos+2) mod L], digit0=stream[(pos+3) mod L]. Characters enter from the right.
- tick counts 0..SCROLL_DIV-1 only in SCROLL with scroll_en=1. It holds its value when scroll_en=0.
- Scroll step: when tick reaches SCROLL_DIV-1, tick returns to 0 and pos advances. If pos == L-1, pos becomes 0 and wrap_pulse=1 in the following cycle. Otherwise pos increments.
- seg_data is registered:
  - SCROLL: reflects pos one cycle after pos changes. The first SCROLL cycle shows all blanks.
  - IDLE: all BLANK_CODE.
  - LOAD (preview): the last min(msg_len,4) characters right-justified, left positions BLANK_CODE, updated the cycle after each write.
- Full buffer: when msg_len==DEPTH, char_ready=0 and char_valid is ignored without error.
- Reset or msg_clear mid-scroll aborts immediately. No further wrap_pulse is issued.
- Arithmetic: pos needs ceil(log2(DEPTH+4)) bits. The mod-L index computation must not overflow for L up to DEPTH+4.

Test Plan:
1. Reset -> seg_data=20'hFFFFF, msg_len=0, char_ready=1, scrolling=0.
2. With DEPTH=8, SCROLL_DIV=4: write 01,02,03, then commit.
   - Windows (d3..d0), each step 4 cycles apart: (1F,1F,1F,1F), (1F,1F,1F,01)=20'hFFFE1, (1F,1F,01,02), (1F,01,02,03), (01,02,03,1F), (02,03,1F,1F), (03,1F,1F,1F).
   - Then all-blank again, with one wrap_pulse.
3. LOAD preview: write 0A,0B,0C,0D,0E -> after the last write, seg_data=(0B,0C,0D,0E) and msg_len=5.
4. Fill 8 chars -> char_ready=0. A ninth char_valid is held 3 cycles -> msg_len stays 8, buffer unchanged.
5. Mid-scroll, scroll_en=0 for 10 cycles -> seg_data and tick frozen. Re-enable -> step occurs after the remaining ticks.
6. msg_clear and char_valid asserted together in LOAD -> next cycle IDLE, msg_len=0, seg_data=20'hFFFFF. A commit in IDLE has no effect.

Source files
------------

// File: rtl/seg_text_scroller.sv
// seg_text_scroller
//   Producer side of a 4-digit 7-segment display. It loads a message of 5-bit
//   character codes over a valid/ready port and stores it in a small buffer.
//   It then scrolls the message right-to-left through a 4-character window and
//   drives the packed seg_data word read by the display multiplexer.
//
// Ports:
//   clk         system clock, everything on the rising edge
//   reset       synchronous, active-high reset
//   char_in     character code to append to the message
//   char_valid  char_in valid; a write happens on char_valid && char_ready
//   char_ready  buffer accepts a character this cycle
//   msg_commit  pulse: stop loading and start scrolling
//   msg_clear   pulse: discard the message and return to idle
//   scroll_en   1 = scrolling advances, 0 = window frozen
//   seg_data    {digit3 (leftmost) [19:15], digit2, digit1, digit0 [4:0]}
//   msg_len     number of stored characters
//   scrolling   high while scrolling
//   wrap_pulse  one-cycle pulse when the window returns to position 0
module seg_text_scroller #(
    parameter int          DEPTH      = 16,
    parameter int          SCROLL_DIV = 25000000,
    parameter logic [4:0]  BLANK_CODE = 5'h1F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    input  logic        msg_commit,
    input  logic        msg_clear,
    input  logic        scroll_en,
    output logic [19:0] seg_data,
    output logic [4:0]  msg_len,
    output logic        scrolling,
    output logic        wrap_pulse
);

    localparam int PW = $clog2(DEPTH + 4);   // scroll position width
    localparam int IW = PW + 1;              // holds L and pos+3 without overflow
    localparam int TW = $clog2(SCROLL_DIV);
    localparam int BW = $clog2(DEPTH);

    localparam logic [19:0]   BLANK_WORD = {4{BLANK_CODE}};
    localparam logic [TW-1:0] TICK_LAST  = TW'(SCROLL_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SCROLL
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [4:0]      r_buf [DEPTH];
    logic [4:0]      r_len;
    logic [PW-1:0]   r_pos;
    logic [TW-1:0]   r_tick;
    logic [19:0]     r_seg;
    logic            r_wrap;

    logic            w_write;
    logic [IW-1:0]   w_stream_len;
    logic [IW-1:0]   w_idx [4];
    logic [IW-1:0]   w_off [4];
    logic [19:0]     w_window;

    assign w_stream_len = IW'(r_len) + IW'(4);

    // Next state, handshake and status outputs.
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        char_ready  = 1'b0;
        scrolling   = 1'b0;
        case (r_state)
            S_IDLE:   char_ready = 1'b1;
            S_LOAD:   char_ready = (r_len < 5'(DEPTH));
            S_SCROLL: scrolling  = 1'b1;
            default:  char_ready = 1'b0;
        endcase
        // A clear drops any character offered in the same cycle.
        w_write = char_valid && char_ready && !msg_clear;
        if (msg_clear) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (w_write)    w_state_nxt = S_LOAD;
                S_LOAD:   if (msg_commit) w_state_nxt = S_SCROLL;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    // Window over the virtual stream: four leading blanks followed by the
    // message, indexed modulo L. pos+k never exceeds 2L-1, so a single
    // conditional subtract is enough.
    // NOTE: blocking assignments here, because later statements read the
    // values just computed in the same evaluation.
    always_comb begin
        w_window = BLANK_WORD;
        for (int k = 0; k < 4; k++) begin
            w_idx[k] = IW'(r_pos) + IW'(k);
            if (w_idx[k] >= w_stream_len) begin
                w_idx[k] = w_idx[k] - w_stream_len;
            end
            w_off[k] = w_idx[k] - IW'(4);
            if (w_idx[k] >= IW'(4)) begin
                w_window[19 - 5*k -: 5] = r_buf[w_off[k][BW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the message buffer has no reset; msg_len alone says which
    // entries are meaningful, so stale contents are never shown.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_buf[r_len[BW-1:0]] <= char_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_len  <= '0;
            r_pos  <= '0;
            r_tick <= '0;
            r_seg  <= BLANK_WORD;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (msg_clear) begin
                r_len  <= '0;
                r_pos  <= '0;
                r_tick <= '0;
                r_seg  <= BLANK_WORD;
            end else begin
                if (w_write) begin
                    r_len <= r_len + 5'd1;
                    // Preview: shifting each new character in from the right
                    // of an all-blank word leaves the last four right-justified.
                    r_seg <= {r_seg[14:0], char_in};
                end
                if (r_state == S_LOAD && msg_commit) begin
                    r_pos  <= '0;
                    r_tick <= '0;
                    r_seg  <= BLANK_WORD;
                end else if (r_state == S_SCROLL) begin
                    r_seg <= w_window;
                    if (scroll_en) begin
                        if (r_tick == TICK_LAST) begin
                            r_tick <= '0;
                            if (r_pos == PW'(w_stream_len - IW'(1))) begin
                                r_pos  <= '0;
                                r_wrap <= 1'b1;
                            end else begin
                                r_pos <= r_pos + PW'(1);
                            end
                        end else begin
                            r_tick <= r_tick + TW'(1);
                        end
                    end
                end
            end
        end
    end

    assign seg_data   = r_seg;
    assign msg_len    = r_len;
    assign wrap_pulse = r_wrap;

endmodule
